// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared load/store encodings and memory-stage state type
package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_t;

    // Unused funct3 codes fall back to a full-word access.
    function automatic acc_size_t acc_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: acc_size = SZ_B;
            F3_H, F3_HU: acc_size = SZ_H;
            F3_W:        acc_size = SZ_W;
            default:     acc_size = SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
        case (acc_size(f3))
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = lsb[0];
            default: is_misaligned = (lsb != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/halfword lane and extends it
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lsb,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    always_comb begin
        w_byte   = 8'(i_rdata >> {i_addr_lsb, 3'b000});
        w_half   = i_addr_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_signed = (i_funct3 == F3_B) || (i_funct3 == F3_H);
        case (acc_size(i_funct3))
            SZ_B:    o_data = {{24{w_signed & w_byte[7]}}, w_byte};
            SZ_H:    o_data = {{16{w_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: data-memory handshake, store lanes, load alignment
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [31:0]       pc_i,
    input  logic [ADDR_W-1:0] alu_res_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              reg_write_i,
    input  logic [2:0]        funct3_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              misalign_o,
    output logic [31:0]       pc_o,
    output logic [ADDR_W-1:0] alu_res_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [4:0]        rd_addr_o,
    output logic              wb_o
);

    mem_state_t        r_state;
    logic [DATA_W-1:0] r_ld_q;

    logic              w_mem_op;
    logic              w_misalign;
    logic              w_issue;
    logic              w_req;
    logic [DATA_W-1:0] w_load_word;

    assign w_mem_op   = valid_i & (mem_read_i | mem_write_i);
    assign w_misalign = is_misaligned(funct3_i, alu_res_i[1:0]);
    assign w_issue    = w_mem_op & ~w_misalign;
    // WAIT keeps requesting regardless of inputs; EX/MEM is frozen by stall_o.
    assign w_req      = ((r_state == ST_IDLE) & w_issue) | (r_state == ST_WAIT);

    load_align u_load_align (
        .i_rdata    (mem_rdata_i),
        .i_addr_lsb (alu_res_i[1:0]),
        .i_funct3   (funct3_i),
        .o_data     (w_load_word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ld_q  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_issue) r_state <= mem_ack_i ? ST_DONE : ST_WAIT;
                ST_WAIT: if (mem_ack_i) r_state <= ST_DONE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_req && mem_ack_i) r_ld_q <= w_load_word;
        end
    end

    assign mem_req_o  = w_req;
    assign stall_o    = w_req;
    assign mem_we_o   = mem_write_i;
    assign mem_addr_o = {alu_res_i[ADDR_W-1:2], 2'b00};
    assign pc_o       = pc_i;
    assign alu_res_o  = alu_res_i;
    assign rd_addr_o  = rd_addr_i;

    always_comb begin
        mem_wdata_o = store_data_i;
        mem_be_o    = 4'b1111;
        case (acc_size(funct3_i))
            SZ_B: begin
                mem_wdata_o = {4{store_data_i[7:0]}};
                mem_be_o    = 4'b0001 << alu_res_i[1:0];
            end
            SZ_H: begin
                mem_wdata_o = {2{store_data_i[15:0]}};
                mem_be_o    = 4'b0011 << alu_res_i[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        misalign_o  = 1'b0;
        wb_o        = 1'b0;
        read_data_o = '0;
        case (r_state)
            ST_IDLE: begin
                misalign_o = w_mem_op & w_misalign;
                wb_o       = valid_i & reg_write_i & ~w_mem_op;
            end
            ST_DONE: begin
                wb_o        = reg_write_i & mem_read_i;
                read_data_o = r_ld_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] alu_res_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_addr_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        reg_write_i;
    logic [2:0]  funct3_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        misalign_o;
    logic [31:0] pc_o;
    logic [31:0] alu_res_o;
    logic [31:0] read_data_o;
    logic [4:0]  rd_addr_o;
    logic        wb_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    mem_access_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .pc_i         (pc_i),
        .alu_res_i    (alu_res_i),
        .store_data_i (store_data_i),
        .rd_addr_i    (rd_addr_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .reg_write_i  (reg_write_i),
        .funct3_i     (funct3_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o),
        .pc_o         (pc_o),
        .alu_res_o    (alu_res_o),
        .read_data_o  (read_data_o),
        .rd_addr_o    (rd_addr_o),
        .wb_o         (wb_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int unsigned acc_bytes(input logic [2:0] f3);
        if (f3 % 4 == 0) return 1;
        if (f3 % 4 == 1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [2:0] f3);
        int unsigned nb;
        longint      v;
        nb = acc_bytes(f3);
        if (nb == 4) return rdata;
        v = (longint'(rdata) >> (8 * (addr % 4))) % (longint'(1) << (8 * nb));
        if (f3 < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_be(input logic [31:0] addr, input logic [2:0] f3);
        int unsigned nb;
        nb = acc_bytes(f3);
        if (nb == 1) return 32'(1 << (addr % 4));
        if (nb == 2) return 32'(3 << (addr % 4));
        return 32'd15;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] sd, input logic [2:0] f3);
        int unsigned nb;
        nb = acc_bytes(f3);
        if (nb == 1) return (sd % 256) * 32'h01010101;
        if (nb == 2) return (sd % 65536) * 32'h00010001;
        return sd;
    endfunction

    task automatic do_op(input logic v, input logic mr, input logic mw, input logic rw,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rdata, input int nreq);
        logic is_mem;
        logic mis;
        int   stalls;
        valid_i = v; mem_read_i = mr; mem_write_i = mw; reg_write_i = rw;
        funct3_i = f3; alu_res_i = addr; store_data_i = sd;
        pc_i = $urandom; rd_addr_i = 5'($urandom);
        mem_ack_i = 1'b0; mem_rdata_i = $urandom;
        is_mem = v & (mr | mw);
        mis = is_mem && (addr % acc_bytes(f3) != 0);
        #1;
        check_val("pc_pass", pc_o, pc_i);
        check_val("alu_pass", alu_res_o, addr);
        check_val("rd_pass", 32'(rd_addr_o), 32'(rd_addr_i));
        if (!is_mem) begin
            check_val("nomem_wb", 32'(wb_o), 32'(v & rw));
            check_val("nomem_req", 32'(mem_req_o), 0);
            check_val("nomem_stall", 32'(stall_o), 0);
            check_val("nomem_rdata", read_data_o, 0);
            check_val("nomem_misalign", 32'(misalign_o), 0);
            step();
            return;
        end
        if (mis) begin
            check_val("mis_pulse", 32'(misalign_o), 1);
            check_val("mis_req", 32'(mem_req_o), 0);
            check_val("mis_stall", 32'(stall_o), 0);
            check_val("mis_wb", 32'(wb_o), 0);
            step();
            return;
        end
        stalls = 0;
        for (int k = 1; k <= nreq; k++) begin
            mem_ack_i   = (k == nreq);
            mem_rdata_i = (k == nreq) ? rdata : $urandom;
            #1;
            if (stall_o === 1'b1) stalls++;
            check_val("req_high", 32'(mem_req_o), 1);
            check_val("req_wb", 32'(wb_o), 0);
            check_val("req_misalign", 32'(misalign_o), 0);
            check_val("req_addr", mem_addr_o, addr - (addr % 4));
            check_val("req_we", 32'(mem_we_o), 32'(mw));
            if (mw) begin
                check_val("req_be", 32'(mem_be_o), exp_be(addr, f3));
                check_val("req_wdata", mem_wdata_o, exp_wdata(sd, f3));
            end
            step();
        end
        check_val("stall_cycles", stalls, nreq);
        mem_ack_i   = 1'($urandom);
        mem_rdata_i = $urandom;
        #1;
        check_val("done_req", 32'(mem_req_o), 0);
        check_val("done_stall", 32'(stall_o), 0);
        check_val("done_wb", 32'(wb_o), 32'(rw & mr));
        if (mr && !mw) check_val("done_rdata", read_data_o, exp_load(rdata, addr, f3));
        step();
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 0; pc_i = 0; alu_res_i = 0; store_data_i = 0; rd_addr_i = 0;
        mem_read_i = 0; mem_write_i = 0; reg_write_i = 0; funct3_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0;
        step();
        step();
        rst_i = 1'b0;
        #1;
        check_val("rst_req", 32'(mem_req_o), 0);
        check_val("rst_stall", 32'(stall_o), 0);
        check_val("rst_rdata", read_data_o, 0);
        check_val("rst_wb", 32'(wb_o), 0);
        step();

        do_op(1, 0, 0, 1, 3'b010, 32'h0000_1234, 0, 0, 1);
        do_op(1, 1, 0, 1, 3'b000, 32'h0000_1003, 0, 32'h80FF_0000, 3);
        do_op(1, 1, 0, 1, 3'b101, 32'h0000_2002, 0, 32'hBEEF_1234, 1);
        do_op(1, 0, 1, 0, 3'b000, 32'h0000_3001, 32'h0000_00AB, 0, 2);
        do_op(1, 1, 0, 1, 3'b010, 32'h0000_4002, 0, 0, 1);

        // Abandon a load in WAIT with reset, then offer a stray ack.
        valid_i = 1; mem_read_i = 1; mem_write_i = 0; reg_write_i = 1;
        funct3_i = 3'b010; alu_res_i = 32'h0000_5000; mem_ack_i = 0;
        #1;
        check_val("wr_req_idle", 32'(mem_req_o), 1);
        step();
        check_val("wr_req_wait", 32'(mem_req_o), 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        mem_read_i = 0; alu_res_i = 32'h0000_0077; mem_ack_i = 1;
        #1;
        check_val("wr_after_req", 32'(mem_req_o), 0);
        check_val("wr_after_stall", 32'(stall_o), 0);
        check_val("wr_after_wb", 32'(wb_o), 1);
        step();
        mem_ack_i = 0;
        #1;
        check_val("wr_stray_req", 32'(mem_req_o), 0);
        check_val("wr_stray_wb", 32'(wb_o), 1);
        check_val("wr_stray_rdata", read_data_o, 0);
        step();

        for (int i = 0; i < 300; i++) begin
            int          kind;
            logic [31:0] addr;
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            kind = $urandom_range(0, 3);
            case (kind)
                0: do_op(1, 0, 0, 1'($urandom), 3'($urandom), addr, $urandom, $urandom, 1);
                1: do_op(1, 1, 0, 1'($urandom), 3'($urandom_range(0, 7)), addr, 0, $urandom,
                         $urandom_range(1, 4));
                2: do_op(1, 0, 1, 0, 3'($urandom_range(0, 2)), addr, $urandom, $urandom,
                         $urandom_range(1, 4));
                default: do_op(0, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), addr,
                               $urandom, $urandom, 1);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
